// File: rtl/seg_pkg.sv
// Shared constants and width helpers for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int cnt_width(input int prescale);
    return $clog2(prescale);
  endfunction

  function automatic int idx_width(input int digits);
    return $clog2(digits);
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned
// commits and optional leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_W = cnt_width(PRESCALE);
  localparam int IDX_W = idx_width(DIGITS);

  typedef logic [DIGITS-1:0][3:0] nib_vec_t;

  nib_vec_t           pend_val, disp_val, disp_val_nxt;
  logic [DIGITS-1:0]  pend_dp, disp_dp, disp_dp_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               tick, wrap;
  logic [DIGITS-1:0]  any_nz, blank;
  logic [3:0]         nib;
  logic [6:0]         font_seg;

  // NOTE: every signal gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tick         = enable && (cnt == CNT_W'(PRESCALE - 1));
    wrap         = tick && (idx == IDX_W'(DIGITS - 1));
    cnt_nxt      = '0;
    idx_nxt      = '0;
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    if (enable) begin
      cnt_nxt = tick ? '0 : cnt + 1'b1;
      idx_nxt = idx;
      if (tick) idx_nxt = wrap ? '0 : idx + 1'b1;
    end
    // A load coinciding with the wrap bypasses the pending register.
    if (wrap) begin
      disp_val_nxt = load ? nib_vec_t'(value) : pend_val;
      disp_dp_nxt  = load ? dp_in : pend_dp;
    end
  end

  // Prefix-OR from the most significant digit down: a digit is a leading
  // zero when it and everything above it is zero.
  always_comb begin
    any_nz[DIGITS-1] = |disp_val_nxt[DIGITS-1];
    for (int k = DIGITS - 2; k >= 0; k--)
      any_nz[k] = any_nz[k+1] | (|disp_val_nxt[k]);
    blank    = lz_blank ? ~any_nz : '0;
    blank[0] = 1'b0;
  end

  assign nib = disp_val_nxt[idx_nxt];

  hex7_decode u_dec (
    .nibble (nib),
    .seg    (font_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; pending/display are plain registers and are
  // reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      an       <= '1;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
      frame    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
      frame    <= wrap;
      if (load) begin
        pend_val <= nib_vec_t'(value);
        pend_dp  <= dp_in;
      end
      // Outputs come from next-state idx/display so an, seg and dp move together.
      if (enable) begin
        an  <= ~(DIGITS'(1) << idx_nxt);
        seg <= blank[idx_nxt] ? SEG_OFF : font_seg;
        dp  <= ~disp_dp_nxt[idx_nxt];
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, PRESCALE=4) against a
// phase-counter reference model.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int total = 0;
  int bad   = 0;

  // Reference model: one position counter 0..15 across the whole frame.
  logic [6:0]  font [16];
  int          phase;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_frame;

  seg_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .lz_blank (lz_blank),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_frame = 1'b0;
  endtask

  task automatic model_edge();
    int k;
    logic [3:0] nibv;
    logic blank_k;
    if (enable) begin
      phase = (phase + 1) % 16;
      if (phase == 0) begin
        m_disp = load ? value : m_pend;
        m_ddp  = load ? dp_in : m_pdp;
      end
      exp_frame = (phase == 0);
    end else begin
      phase = 0;
      exp_frame = 1'b0;
    end
    if (load) begin
      m_pend = value;
      m_pdp  = dp_in;
    end
    if (enable) begin
      k       = phase / 4;
      nibv    = 4'((m_disp >> (4 * k)) & 16'hF);
      blank_k = lz_blank && (k != 0) && ((m_disp >> (4 * k)) == 16'h0);
      exp_an  = ~(4'b0001 << k);
      exp_seg = blank_k ? 7'h7F : font[nibv];
      exp_dp  = ~m_ddp[k];
    end else begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end
  endtask

  task automatic check_all();
    check("an", 16'(an), 16'(exp_an));
    check("seg", 16'(seg), 16'(exp_seg));
    check("dp", 16'(dp), 16'(exp_dp));
    check("frame", 16'(frame), 16'(exp_frame));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_all();
    #9 rst = 1'b0;

    // Basic scan with a loaded value
    enable = 1'b1; load = 1'b1; value = 16'h1A80;
    step();
    check("first_an", 16'(an), 16'hE);
    run(40);

    // Tear-free commit: load zeros while digit 2 is lit
    for (int i = 0; i < 16 && (phase / 4) != 2; i++) step();
    load = 1'b1; value = 16'h0000;
    run(24);

    // Load coinciding with the wrap tick bypasses pending
    for (int i = 0; i < 16 && phase != 15; i++) step();
    load = 1'b1; value = 16'hFFFF;
    step();
    check("coinc_seg", 16'(seg), 16'h0E);
    check("coinc_frame", 16'(frame), 16'h1);
    run(16);

    // Leading-zero suppression
    lz_blank = 1'b1; load = 1'b1; value = 16'h0050;
    run(36);
    load = 1'b1; value = 16'h0000;
    run(36);
    lz_blank = 1'b0;

    // Decimal point and enable toggling
    load = 1'b1; value = 16'h1234; dp_in = 4'b0100;
    run(36);
    enable = 1'b0;
    step();
    check("dis_an", 16'(an), 16'hF);
    enable = 1'b1;
    step();
    check("en_an", 16'(an), 16'hE);
    run(20);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        load  = 1'b1;
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
      step();
    end

    // Asynchronous reset mid-scan
    enable = 1'b1; lz_blank = 1'b0;
    run(6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dp), 16'h1);
    check("rst_frame", 16'(frame), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rel_an", 16'(an), 16'hE);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It is the parametrised successor of the single-digit hex decoder. The block latches a packed hex value, scans one digit per PRESCALE clock cycles, decodes each nibble to active-low segments (seg[0]=a … seg[6]=g), and optionally blanks leading zeros. New values are committed only at a frame boundary so a digit never shows a half-updated value. It sits between the system status logic and the board display pins.

## Interface
- DIGITS, 4: number of digits scanned, ≥2.
- PRESCALE, 50000: clock cycles each digit stays lit, ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  display on; low forces all digits dark.
- load  in  1  single-cycle strobe; captures value/dp_in.
- value  in  4*DIGITS  packed nibbles; digit k = value[4k+3:4k], digit 0 rightmost/LSB.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- lz_blank  in  1  suppress leading zeros.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  DIGITS  digit select, active-low one-hot, registered.
- frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Registers:
  - pending value/dp, loaded on load;
  - display value/dp;
  - prescaler cnt (0..PRESCALE-1);
  - digit index idx (0..DIGITS-1).
- tick = (cnt == PRESCALE-1) with enable high. On tick: cnt←0 and idx←(idx==DIGITS-1)?0:idx+1. Otherwise cnt increments.
- Commit: on the tick where idx wraps to 0, display←pending. If load is high in that same cycle, display←value/dp_in directly (bypass), and pending also takes the new data.
- Output registers update every cycle from the next-state idx:
  - an = ~(1<<idx);
  - seg = decode(display nibble idx);
  - dp = ~display_dp[idx].
- Decode uses the standard hex font:
  - 0→0x40, 1→0x79, 8→0x00, A→0x08, F→0x0E;
  - segment a is lit for 6, 7 and 9; segment d is lit for 9; a is dark for 1, 4, b, d.
- Leading-zero suppression: with lz_blank=1, digit k is blanked (seg=0x7F) when every nibble from DIGITS-1 down to k is zero. Digit 0 is never blanked. dp is unaffected by blanking.
- enable=0: next cycle an=all ones, seg=0x7F, dp=1, cnt←0, idx←0, frame=0. pending still accepts load. On enable 0→1, digit 0 is driven in the following cycle.

## Timing
- Reset (async, asserted): an=all ones, seg=0x7F, dp=1, frame=0, cnt=0, idx=0, pending=0, display=0.
- After reset release with enable=1:
  - digit 0 is driven on the first clock edge;
  - each digit is held exactly PRESCALE cycles;
  - a full frame lasts DIGITS*PRESCALE cycles.
- frame is asserted in the cycle in which an first shows digit 0 of a new frame.
- Load-to-display latency: at most DIGITS*PRESCALE+1 cycles.
- Back-to-back loads: the last load before the commit wins. Loads between commits are otherwise invisible.
- an changes in the same cycle as seg and dp. There is no ghosting cycle; all three come from one register stage.
- Reset mid-frame blanks all outputs immediately, independent of clk.

## Structure
- Package seg_pkg holds:
  - the SEG_OFF (7'h7F) constant;
  - the 16-entry hex font constant array;
  - localparam helper for the counter width ($clog2(PRESCALE)) and the index width ($clog2(DIGITS)).
- One combinational sub-module, hex7_decode (4-bit nibble → 7-bit active-low segments), instantiated once on the muxed nibble.
- Leading-zero logic is a DIGITS-wide prefix-OR in the top module.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4.
- Reset: assert rst mid-scan → an=4'hF, seg=7'h7F, dp=1 in the same cycle. Release → an=4'hE on the first edge.
- Scan: load value=16'h1A80, enable=1 → after the commit, per 4-cycle slot:
  - an=E, seg=0x40;
  - an=D, seg=0x00;
  - an=B, seg=0x08;
  - an=7, seg=0x79;
  - frame pulses every 16 cycles.
- Tear-free commit: load 16'h0000 while digit 2 is lit → the old value persists until frame. The new value appears from digit 0 of the next frame.
- Coincident load and wrap: load 16'hFFFF in the tick cycle → digit 0 of the new frame shows 0x0E.
- Leading zeros: lz_blank=1, value=16'h0050 →
  - digits 3 and 2 show seg=7'h7F;
  - digit 1 shows 5;
  - digit 0 shows 0x40.
  - value=16'h0000 → only digit 0 is lit, showing 0x40.
- Enable/dp: dp_in=4'b0100 → dp=0 only while an=B. Drop enable → next cycle an=F. Raise enable → an=E the next cycle with cnt restarted.
